// File: rtl/edge_capture_pkg.sv
// Shared entry layout and polarity encoding
// for the edge capture scheduler.
package edge_capture_pkg;

  localparam int   POL_W    = 1;
  localparam logic POL_RISE = 1'b1;
  localparam logic POL_FALL = 1'b0;

  // Packed entry is {channel, polarity, timestamp}
  function automatic int entry_w(int ch_w, int ts_w);
    return ch_w + POL_W + ts_w;
  endfunction

endpackage

// File: rtl/edge_capture_arbiter_if.sv
// Capture-entry valid/ready stream between
// the scheduler and its consumer.
interface edge_capture_arbiter_if #(
  parameter int CH_W     = 2,
  parameter int TS_WIDTH = 32
);

  logic                cap_valid;
  logic                cap_ready;
  logic [CH_W-1:0]     cap_channel;
  logic                cap_polarity;
  logic [TS_WIDTH-1:0] cap_timestamp;

  modport master (
    output cap_valid,
    output cap_channel,
    output cap_polarity,
    output cap_timestamp,
    input  cap_ready
  );

  modport slave (
    input  cap_valid,
    input  cap_channel,
    input  cap_polarity,
    input  cap_timestamp,
    output cap_ready
  );

endinterface

// File: rtl/capture_fifo.sv
// First-word-fall-through FIFO holding packed
// capture entries; head is visible while valid.
module capture_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   level_q, level_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (level_q != '0);
  assign do_push = push_i && (level_q != (AW+1)'(DEPTH));

  always_comb begin
    level_d = level_q;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= din_i;
  end

  assign dout_o  = mem[rd_q];
  assign valid_o = (level_q != '0);
  assign level_o = level_q;

endmodule

// File: rtl/edge_capture_arbiter.sv
// Timestamps per-channel edge events into pending
// slots and round-robins them into a capture FIFO.
module edge_capture_arbiter
  import edge_capture_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int TS_WIDTH   = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        nrst,
  input  logic                        enable,
  input  logic [CH_NUM-1:0]           ch_mask,
  input  logic [CH_NUM-1:0]           pos_edge,
  input  logic [CH_NUM-1:0]           neg_edge,
  edge_capture_arbiter_if.master      cap,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CH_NUM-1:0]           overrun,
  input  logic                        clr_overrun
);

  localparam int CH_W  = $clog2(CH_NUM);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int EW    = entry_w(CH_W, TS_WIDTH);

  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [CH_NUM-1:0]   sv_q, sv_d;
  logic [CH_NUM-1:0]   spol_q, spol_d;
  logic [CH_NUM-1:0]   ovr_q, ovr_d;
  logic [TS_WIDTH-1:0] sts_q [CH_NUM];
  logic [TS_WIDTH-1:0] sts_d [CH_NUM];

  logic                gnt;
  logic [CH_W-1:0]     gnt_ch;
  logic [CH_W-1:0]     idx;
  logic [CH_NUM-1:0]   gnt_oh;
  logic                full;
  logic [EW-1:0]       push_data;
  logic [EW-1:0]       head;
  logic                head_valid;
  logic                pop;

  // Registered level only, so a pop never frees a slot the same cycle
  assign full = (fifo_level >= LVL_W'(FIFO_DEPTH));

  always_comb begin
    gnt    = 1'b0;
    gnt_ch = '0;
    idx    = '0;
    gnt_oh = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      idx = CH_W'((int'(rr_q) + k) % CH_NUM);
      if (!gnt && !full && sv_q[idx]) begin
        gnt    = 1'b1;
        gnt_ch = idx;
      end
    end
    if (gnt) gnt_oh[gnt_ch] = 1'b1;
  end

  always_comb begin
    ts_d   = enable ? ts_q + TS_WIDTH'(1) : ts_q;
    rr_d   = rr_q;
    sv_d   = sv_q;
    spol_d = spol_q;
    sts_d  = sts_q;
    ovr_d  = clr_overrun ? '0 : ovr_q;
    if (gnt)
      rr_d = (gnt_ch == CH_W'(CH_NUM-1)) ? '0 : gnt_ch + CH_W'(1);
    for (int i = 0; i < CH_NUM; i++) begin
      if (gnt_oh[i]) sv_d[i] = 1'b0;
      if (enable && ch_mask[i] && (pos_edge[i] || neg_edge[i])) begin
        // Oldest event wins; a slot freed by this cycle's grant reloads
        if (sv_q[i] && !gnt_oh[i]) begin
          ovr_d[i] = 1'b1;
        end else begin
          sv_d[i]   = 1'b1;
          spol_d[i] = pos_edge[i] ? POL_RISE : POL_FALL;
          sts_d[i]  = ts_q;
          if (pos_edge[i] && neg_edge[i]) ovr_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ts_q   <= '0;
      rr_q   <= '0;
      sv_q   <= '0;
      spol_q <= '0;
      ovr_q  <= '0;
      for (int i = 0; i < CH_NUM; i++) sts_q[i] <= '0;
    end else begin
      ts_q   <= ts_d;
      rr_q   <= rr_d;
      sv_q   <= sv_d;
      spol_q <= spol_d;
      ovr_q  <= ovr_d;
      sts_q  <= sts_d;
    end
  end

  assign push_data = {gnt_ch, spol_q[gnt_ch], sts_q[gnt_ch]};
  assign pop       = head_valid && cap.cap_ready;

  capture_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .push_i  (gnt),
    .din_i   (push_data),
    .pop_i   (pop),
    .dout_o  (head),
    .valid_o (head_valid),
    .level_o (fifo_level)
  );

  assign cap.cap_valid = head_valid;
  assign {cap.cap_channel, cap.cap_polarity, cap.cap_timestamp} = head;
  assign overrun = ovr_q;

endmodule

// File: doc/edge_capture_arbiter.md
# edge_capture_arbiter

Multi-channel edge-event capture scheduler for encoder/Hall/fault inputs. Accepts single-cycle `pos_edge`/`neg_edge` pulses from a bank of per-channel edge detectors, timestamps each event against a free-running counter, and arbitrates round-robin into one shared capture FIFO. Downstream logic (speed/position estimation, bus register interface) drains the FIFO over a valid/ready handshake.

## Interface
- `CH_NUM`, default 4: number of edge-detector channels (2..16).
- `TS_WIDTH`, default 32: timestamp counter width.
- `FIFO_DEPTH`, default 8: capture FIFO depth, power of two, ≥2.
- `clk` in 1: single clock. All logic is on its rising edge.
- `nrst` in 1: asynchronous, active-low reset.
- `enable` in 1: global capture and timestamp enable.
- `ch_mask` in CH_NUM: per-channel enable. 1 means the channel is captured.
- `pos_edge` in CH_NUM: rising-edge event pulses, one cycle wide.
- `neg_edge` in CH_NUM: falling-edge event pulses, one cycle wide.
- `cap_valid` out 1: FIFO head entry is valid.
- `cap_ready` in 1: consumer accepts the head entry.
- `cap_channel` out clog2(CH_NUM): channel index of the head entry.
- `cap_polarity` out 1: 1 = rising edge, 0 = falling edge.
- `cap_timestamp` out TS_WIDTH: timestamp of the head entry.
- `fifo_level` out clog2(FIFO_DEPTH)+1: number of entries in the FIFO.
- `overrun` out CH_NUM: sticky per-channel flag for a lost event.
- `clr_overrun` in 1: pulse that clears all `overrun` bits.

## Operation
- **Reset values:** `ts`=0, `rr_ptr`=0, all pending slots empty, FIFO empty, `cap_valid`=0, `fifo_level`=0, `overrun`=0.
- **Timestamp counter `ts`:** increments by 1 each cycle while `enable`=1. Wraps from 2^TS_WIDTH−1 to 0 with no flag. Holds its value while `enable`=0.
- **Event qualification:** an event on channel i requires `enable`=1, `ch_mask[i]`=1 and (`pos_edge[i]` or `neg_edge[i]`). Unqualified pulses are ignored and set no flag.
- **Per-channel pending slot:** holds `{valid, polarity, ts}`. On a qualified event the slot loads polarity and the current (pre-increment) `ts`.
- **Slot already valid and not granted this cycle:** the new event is dropped, the oldest event is kept, and `overrun[i]` is set.
- **Slot granted in the same cycle as a new event:** the new event loads and no overrun is flagged.
- **`pos_edge[i]` and `neg_edge[i]` in the same cycle:** capture the rising edge and set `overrun[i]`.
- **Arbiter:** round-robin over valid slots, starting the search at `rr_ptr`. At most one grant per cycle, and only when `fifo_level` < FIFO_DEPTH (the registered level).
  - On a grant to channel g: the slot is cleared, entry `{g, polarity, ts}` is pushed, and `rr_ptr` becomes (g+1) mod CH_NUM.
  - With no grant, `rr_ptr` holds.
- **FIFO:** first-word-fall-through, so the `cap_*` fields are driven from the head entry.
  - A pop occurs when `cap_valid` and `cap_ready` are both 1.
  - A push and a pop in the same cycle leave `fifo_level` unchanged.
  - A full FIFO back-pressures the pending slots. The FIFO itself never overflows.
- **`enable` deasserted:** pending slots and the FIFO continue to drain. Only new capture stops.
- **`clr_overrun`:** clears all overrun bits. If an overrun occurs in the same cycle, the set wins for that channel.
- **`ch_mask[i]` cleared while slot i is pending:** the slot still drains.

## Timing
- Event pulse sampled at edge k → slot valid after edge k.
- Granted at edge k+1 → `cap_valid` after edge k+1 (empty FIFO). Best-case latency is 2 cycles; the captured timestamp is the `ts` value before edge k.
- Worst-case arbitration wait is CH_NUM−1 cycles with the FIFO not full.
- Sustained throughput is one event per cycle.
- `cap_*` fields are stable while `cap_valid`=1 and `cap_ready`=0.
- Reset mid-operation: all state clears asynchronously and in-flight events are lost. Outputs reach their reset values without waiting for a clock.

## Structure
- Package `edge_capture_pkg`: entry field widths (channel, polarity, timestamp), polarity encoding constants `POL_RISE`=1 and `POL_FALL`=0, and entry packing/unpacking width constant.
- Sub-module `capture_fifo`: synchronous FWFT FIFO with clk/nrst, push/pop and level output.
- The pending slots, round-robin arbiter and timestamp counter stay in the top level.

## Test plan
- **Single event:** with `ts`=100, pulse `pos_edge[2]` → one entry {ch=2, pol=1, ts=100}, `cap_valid` 2 cycles later, `overrun`=0.
- **Round-robin:** pulse `neg_edge` on channels 0–3 in the same cycle with `rr_ptr`=1 → entries pop in order 1, 2, 3, 0, all with the same ts.
- **FIFO full:** FIFO_DEPTH=4, `cap_ready`=0, 6 events on channels 0–3 → `fifo_level`=4, and the remaining events wait in slots. A seventh event on an occupied channel sets its `overrun` bit. Raising `cap_ready` drains all entries, oldest first.
- **Grant/arrival collision:** a new event on ch0 in the cycle its slot is granted → both events are captured, `overrun[0]`=0.
- **Wrap and clear:** TS_WIDTH=4, event at ts=15 then at ts=0 → timestamps 15 and 0. `clr_overrun` in the same cycle as an overrun → the bit remains set.
- **Reset mid-operation:** deassert `nrst` with 3 entries queued → `cap_valid`=0, `fifo_level`=0, `ts`=0 immediately.
